acc_seq_ctrl: RTL and testbench
===============================

// Module: acc_seq_ctrl
// PURPOSE
//  Job sequencer for the matrix accelerator; sits between the APB register decode and logic_top.
//  Owns the operand-load phase, per-column ALU stepping and result hand-back.
//  Drives APB wait states (PREADY) and errors (PSLVERR) for accesses that are illegal in the current phase.
//  Runs on HCLK, not the gated clock, so it can request gating on and off and still answer the bus.
// PARAMETERS
//  MAT_DIM     8                  matrix columns; the number of ALU steps per job
//  LOAD_WORDS  64                 operand words that must be written before compute starts
//  COL_W       $clog2(MAT_DIM)    column counter width
//  CNT_W       $clog2(LOAD_WORDS+1)  load word counter width
//  STALL_MAX   255                max PREADY-low cycles before an access is errored
// PORTS
//  HCLK          in   1      system clock
//  HRESETn       in   1      asynchronous active-low reset
//  start_i       in   1      1-cycle pulse, decoded write of 1 to CTRL (offset 0x0)
//  abort_i       in   1      1-cycle pulse, decoded write of 0 to CTRL
//  access_i      in   1      PSEL && PENABLE
//  write_i       in   1      PWRITE, qualified by access_i
//  data_sel_i    in   1      access targets the operand/result window (offset != 0)
//  alu_done_i    in   1      1-cycle pulse, ALU finished the current column
//  load_en_o     out  1      operand buffer write enable
//  alu_en_o      out  1      ALU step enable, 1-cycle pulse per column
//  col_counter_o out  COL_W  column being computed
//  words_o       out  CNT_W  operand words accepted in this job
//  clk_req_o     out  1      request the gated clock to run
//  busy_o        out  1      job active (LOAD, CALC, WAIT)
//  acc_finish_o  out  1      level; result is valid
//  pready_o      out  1      APB ready
//  pslverr_o     out  1      APB error, valid only when pready_o=1
// BEHAVIOUR
//  Reset: every output is 0 except pready_o=1. State=IDLE. All counters are 0.
//  States: IDLE, LOAD, CALC, WAIT, DONE. All outputs are registered except pready_o and pslverr_o.
//  IDLE -> LOAD on start_i. This clears words_o and col_counter_o and sets clk_req_o=1.
//  LOAD:
//   - An access with write_i && data_sel_i pulses load_en_o on the next cycle and increments words_o.
//   - When words_o reaches LOAD_WORDS: go to CALC.
//  CALC: pulse alu_en_o for one cycle, then go to WAIT.
//  WAIT:
//   - On alu_done_i with col_counter_o != MAT_DIM-1: increment col_counter_o and go to CALC.
//   - On alu_done_i with col_counter_o == MAT_DIM-1: go to DONE.
//  DONE:
//   - acc_finish_o=1 and clk_req_o stays 1 so results can be read.
//   - start_i -> LOAD (new job, acc_finish_o cleared).
//   - abort_i -> IDLE.
//  abort_i in any state -> IDLE on the next cycle, with the same outputs as reset. abort_i wins over a simultaneous start_i.
//  clk_req_o drops to 0 one cycle after entry to IDLE.
//  start_i while in LOAD, CALC or WAIT is ignored. That access completes with pslverr_o=1.
//  Data-window write outside LOAD: not loaded; pslverr_o=1.
//  Data-window read:
//   - In LOAD: pslverr_o=1.
//   - In CALC or WAIT: pready_o=0 until DONE, then pready_o=1 with pslverr_o=0.
//  Stall counter (8-bit):
//   - Counts cycles with pready_o=0.
//   - At STALL_MAX it forces pready_o=1 and pslverr_o=1, and clears.
//   - The state is untouched.
//  No access: pready_o=1, pslverr_o=0.
//  alu_done_i in a state other than WAIT is ignored.
//  Counters never wrap: words_o saturates at LOAD_WORDS.
//  Async reset mid-job: IDLE immediately, no completion is reported.
// STRUCTURE
//  acc_pkg holds:
//   - state enum acc_state_e
//   - register offsets ACC_CTRL_OFS=0x0 and ACC_DATA_OFS
//   - CTRL values ACC_EN_VALUE=1 and ACC_END_VALUE=0
//  One sub-module, acc_stall_timer: the STALL_MAX counter and the forced error.
//  The FSM, counters and response logic live in acc_seq_ctrl.
// TESTING
//  1. Reset, then start_i, 64 data writes, 8 alu_done_i pulses -> exactly 8 alu_en_o pulses with col 0..7, then acc_finish_o=1 and busy_o=0.
//  2. A data read in WAIT (col=3) -> pready_o low until DONE is entered, then 1 with pslverr_o=0.
//  3. start_i at words_o=10 -> pslverr_o=1 and words_o stays 10. A data write in IDLE -> pslverr_o=1 and no load_en_o.
//  4. abort_i together with alu_done_i in WAIT -> next cycle IDLE with all outputs at reset values. clk_req_o=0 one cycle later.
//  5. Withhold alu_done_i with a read pending -> after 255 low cycles pready_o=1 and pslverr_o=1, and the state is still WAIT.
//  6. HRESETn low in CALC, mid-cycle -> outputs clear asynchronously. A new job then completes normally.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types, register map and helpers for the matrix accelerator job sequencer.
package acc_pkg;

    typedef enum logic [2:0] {
        ACC_IDLE,
        ACC_LOAD,
        ACC_CALC,
        ACC_WAIT,
        ACC_DONE
    } acc_state_e;

    localparam logic [11:0] ACC_CTRL_OFS  = 12'h000;
    localparam logic [11:0] ACC_DATA_OFS  = 12'h004;
    localparam logic        ACC_EN_VALUE  = 1'b1;
    localparam logic        ACC_END_VALUE = 1'b0;

    localparam int ACC_MAT_DIM    = 8;
    localparam int ACC_LOAD_WORDS = 64;
    localparam int ACC_STALL_MAX  = 255;
    localparam int ACC_STALL_W    = 8;

    // A job owns the bus-visible operand/result window while loading or computing.
    function automatic logic is_busy(input acc_state_e state);
        return state inside {ACC_LOAD, ACC_CALC, ACC_WAIT};
    endfunction

endpackage

// File: rtl/acc_stall_timer.sv
// Bounds APB wait states: after STALL_MAX held cycles the pending access is released with an error.
module acc_stall_timer
    import acc_pkg::*;
#(
    parameter int STALL_MAX = ACC_STALL_MAX,
    parameter int STALL_W   = ACC_STALL_W
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic hold_i,
    output logic timeout_o
);

    logic [STALL_W-1:0] count_q;

    assign timeout_o = hold_i && (count_q == STALL_W'(STALL_MAX));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            count_q <= '0;
        end else if (!hold_i || timeout_o) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + STALL_W'(1);
        end
    end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Job sequencer: operand load, per-column ALU stepping, result hand-back and APB wait/error response.
module acc_seq_ctrl
    import acc_pkg::*;
#(
    parameter int MAT_DIM    = ACC_MAT_DIM,
    parameter int LOAD_WORDS = ACC_LOAD_WORDS,
    parameter int COL_W      = $clog2(MAT_DIM),
    parameter int CNT_W      = $clog2(LOAD_WORDS + 1),
    parameter int STALL_MAX  = ACC_STALL_MAX
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             access_i,
    input  logic             write_i,
    input  logic             data_sel_i,
    input  logic             alu_done_i,
    output logic             load_en_o,
    output logic             alu_en_o,
    output logic [COL_W-1:0] col_counter_o,
    output logic [CNT_W-1:0] words_o,
    output logic             clk_req_o,
    output logic             busy_o,
    output logic             acc_finish_o,
    output logic             pready_o,
    output logic             pslverr_o
);

    acc_state_e       state_q, state_d;
    logic [COL_W-1:0] col_q;
    logic [CNT_W-1:0] words_q;
    logic             load_en_q, alu_en_q, clk_req_q, busy_q, finish_q;
    logic             data_wr, data_rd, load_wr, last_word, last_col;
    logic             new_job, read_hold, stall_err;

    assign data_wr   = access_i && write_i && data_sel_i;
    assign data_rd   = access_i && !write_i && data_sel_i;
    assign load_wr   = data_wr && (state_q == ACC_LOAD) && (words_q != CNT_W'(LOAD_WORDS));
    assign last_word = load_wr && (words_q == CNT_W'(LOAD_WORDS - 1));
    assign last_col  = (col_q == COL_W'(MAT_DIM - 1));
    assign new_job   = start_i && !abort_i && (state_q == ACC_IDLE || state_q == ACC_DONE);
    // Result reads wait for the job to finish rather than returning partial data.
    assign read_hold = data_rd && (state_q == ACC_CALC || state_q == ACC_WAIT);

    // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = ACC_IDLE;
        end else begin
            case (state_q)
                ACC_IDLE, ACC_DONE: if (start_i) state_d = ACC_LOAD;
                ACC_LOAD:           if (last_word) state_d = ACC_CALC;
                ACC_CALC:           state_d = ACC_WAIT;
                ACC_WAIT:           if (alu_done_i) state_d = last_col ? ACC_DONE : ACC_CALC;
                default:            state_d = ACC_IDLE;
            endcase
        end
    end

    // NOTE: registers update with non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ACC_IDLE;
            words_q   <= '0;
            col_q     <= '0;
            load_en_q <= 1'b0;
            alu_en_q  <= 1'b0;
            clk_req_q <= 1'b0;
            busy_q    <= 1'b0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            load_en_q <= load_wr && !abort_i;
            alu_en_q  <= (state_d == ACC_CALC);
            busy_q    <= is_busy(state_d);
            finish_q  <= (state_d == ACC_DONE);
            // Keep the gated clock for one IDLE cycle so the last result beat settles.
            clk_req_q <= (state_q != ACC_IDLE) || (state_d != ACC_IDLE);
            if (abort_i || new_job) begin
                words_q <= '0;
                col_q   <= '0;
            end else begin
                if (load_wr) words_q <= words_q + CNT_W'(1);
                if (state_q == ACC_WAIT && alu_done_i && !last_col) col_q <= col_q + COL_W'(1);
            end
        end
    end

    acc_stall_timer #(
        .STALL_MAX(STALL_MAX)
    ) u_stall_timer (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .hold_i   (read_hold),
        .timeout_o(stall_err)
    );

    assign pready_o  = !read_hold || stall_err;
    assign pslverr_o = stall_err
                    || (access_i && start_i && is_busy(state_q))
                    || (data_wr && state_q != ACC_LOAD)
                    || (data_rd && state_q == ACC_LOAD);

    assign load_en_o     = load_en_q;
    assign alu_en_o      = alu_en_q;
    assign col_counter_o = col_q;
    assign words_o       = words_q;
    assign clk_req_o     = clk_req_q;
    assign busy_o        = busy_q;
    assign acc_finish_o  = finish_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Randomized bench for acc_seq_ctrl against a job-level reference model (word/column counts per job).
module tb_acc_seq_ctrl;

    localparam int MAT_DIM    = 8;
    localparam int LOAD_WORDS = 64;
    localparam int STALL_MAX  = 255;

    logic       HCLK = 1'b0, HRESETn = 1'b0;
    logic       start_i = 1'b0, abort_i = 1'b0, access_i = 1'b0;
    logic       write_i = 1'b0, data_sel_i = 1'b0, alu_done_i = 1'b0;
    logic       load_en_o, alu_en_o, clk_req_o, busy_o, acc_finish_o, pready_o, pslverr_o;
    logic [2:0] col_counter_o;
    logic [6:0] words_o;

    int         n_checks = 0, n_pass = 0;
    bit         m_active = 1'b0;
    int         m_words = 0, m_cols = 0;
    bit         rd_hold = 1'b0;
    logic [2:0] en_cols[$];

    always #5 HCLK = ~HCLK;

    acc_seq_ctrl dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .access_i     (access_i),
        .write_i      (write_i),
        .data_sel_i   (data_sel_i),
        .alu_done_i   (alu_done_i),
        .load_en_o    (load_en_o),
        .alu_en_o     (alu_en_o),
        .col_counter_o(col_counter_o),
        .words_o      (words_o),
        .clk_req_o    (clk_req_o),
        .busy_o       (busy_o),
        .acc_finish_o (acc_finish_o),
        .pready_o     (pready_o),
        .pslverr_o    (pslverr_o)
    );

    // Independent record of every ALU step the DUT issues.
    always @(negedge HCLK) if (HRESETn && alu_en_o) en_cols.push_back(col_counter_o);

    function automatic bit loading();
        return m_active && (m_words < LOAD_WORDS);
    endfunction

    function automatic bit computing();
        return m_active && (m_words == LOAD_WORDS) && (m_cols < MAT_DIM);
    endfunction

    function automatic bit job_done();
        return m_active && (m_cols == MAT_DIM);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        alu_done_i = 1'b0;
        write_i    = 1'b0;
        access_i   = rd_hold;
        data_sel_i = rd_hold;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},    busy_o,        1'b0);
        check({tag, "_finish"},  acc_finish_o,  1'b0);
        check({tag, "_load_en"}, load_en_o,     1'b0);
        check({tag, "_alu_en"},  alu_en_o,      1'b0);
        check({tag, "_col"},     col_counter_o, 3'd0);
        check({tag, "_words"},   words_o,       7'd0);
        check({tag, "_pready"},  pready_o,      1'b1);
        check({tag, "_pslverr"}, pslverr_o,     1'b0);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_busy"},   busy_o,        loading() || computing());
        check({tag, "_finish"}, acc_finish_o,  job_done());
        check({tag, "_words"},  words_o,       m_words);
        check({tag, "_col"},    col_counter_o, (m_cols == MAT_DIM) ? MAT_DIM - 1 : m_cols);
        check({tag, "_clkreq"}, clk_req_o,     1'b1);
    endtask

    task automatic do_start();
        bit was_busy;
        was_busy   = loading() || computing();
        start_i    = 1'b1;
        access_i   = 1'b1;
        write_i    = 1'b1;
        data_sel_i = 1'b0;
        @(negedge HCLK);
        check("start_pready", pready_o, 1'b1);
        check("start_err", pslverr_o, was_busy);
        tick();
        if (!was_busy) begin
            m_active = 1'b1;
            m_words  = 0;
            m_cols   = 0;
            en_cols.delete();
        end
        check_regs("start");
    endtask

    task automatic do_write();
        bit accept;
        accept     = loading();
        access_i   = 1'b1;
        write_i    = 1'b1;
        data_sel_i = 1'b1;
        @(negedge HCLK);
        check("wr_pready", pready_o, 1'b1);
        check("wr_err", pslverr_o, !accept);
        tick();
        check("wr_load_en", load_en_o, accept);
        if (accept) m_words++;
        if (m_active) check_regs("wr");
        else check("wr_words", words_o, 7'd0);
        if (accept && m_words == LOAD_WORDS) check("calc_alu_en", alu_en_o, 1'b1);
    endtask

    task automatic do_read_short();
        bit exp_err;
        exp_err    = loading();
        access_i   = 1'b1;
        write_i    = 1'b0;
        data_sel_i = 1'b1;
        @(negedge HCLK);
        check("rd_pready", pready_o, 1'b1);
        check("rd_err", pslverr_o, exp_err);
        tick();
    endtask

    task automatic load_phase();
        bit did10;
        int op;
        did10 = 1'b0;
        for (int guard = 0; guard < 2000 && loading(); guard++) begin
            op = $urandom_range(0, 9);
            if (m_words == 10 && !did10) begin
                op    = 1;
                did10 = 1'b1;
            end
            case (op)
                0: do_read_short();
                1: do_start();
                2: begin
                    alu_done_i = 1'b1;
                    tick();
                    check_regs("stray_done");
                end
                3: begin
                    tick();
                    check("idle_load_en", load_en_o, 1'b0);
                    check_regs("idle");
                end
                default: do_write();
            endcase
        end
        check("load_words", words_o, LOAD_WORDS);
    endtask

    task automatic hold_check(input string tag);
        if (rd_hold) check(tag, pready_o, 1'b0);
    endtask

    task automatic enter_wait(input bit stray_done);
        alu_done_i = stray_done;
        @(negedge HCLK);
        hold_check("calc_hold");
        tick();
        check("wait_alu_en", alu_en_o, 1'b0);
        check_regs("wait");
    endtask

    task automatic wait_gap(input int n);
        repeat (n) begin
            @(negedge HCLK);
            hold_check("wait_hold");
            tick();
            check("gap_alu_en", alu_en_o, 1'b0);
            check_regs("gap");
        end
    endtask

    task automatic pulse_done();
        alu_done_i = 1'b1;
        @(negedge HCLK);
        hold_check("done_hold");
        tick();
        m_cols++;
        check_regs("step");
        check("step_alu_en", alu_en_o, m_cols < MAT_DIM);
    endtask

    task automatic compute_all(input int hold_col);
        for (int g = 0; g < MAT_DIM && m_cols < MAT_DIM; g++) begin
            enter_wait(1'($urandom_range(0, 1)));
            if (m_cols == hold_col) begin
                rd_hold    = 1'b1;
                access_i   = 1'b1;
                write_i    = 1'b0;
                data_sel_i = 1'b1;
            end
            wait_gap($urandom_range(0, 3));
            pulse_done();
        end
        if (rd_hold) begin
            @(negedge HCLK);
            check("held_rd_pready", pready_o, 1'b1);
            check("held_rd_err", pslverr_o, 1'b0);
            rd_hold = 1'b0;
            tick();
        end
    endtask

    task automatic check_job_done(input string tag);
        check({tag, "_npulses"}, en_cols.size(), MAT_DIM);
        foreach (en_cols[i]) check({tag, "_pulse_col"}, en_cols[i], i);
        check({tag, "_finish"}, acc_finish_o, 1'b1);
        check({tag, "_busy"},   busy_o,       1'b0);
        check({tag, "_clkreq"}, clk_req_o,    1'b1);
    endtask

    task automatic stall_test();
        int low;
        bit seen;
        low  = 0;
        seen = 1'b0;
        enter_wait(1'b0);
        rd_hold    = 1'b1;
        access_i   = 1'b1;
        write_i    = 1'b0;
        data_sel_i = 1'b1;
        for (int c = 0; c < STALL_MAX + 20; c++) begin
            @(negedge HCLK);
            if (pready_o) begin
                seen = 1'b1;
                check("stall_err", pslverr_o, 1'b1);
                break;
            end
            low++;
            tick();
        end
        check("stall_released", seen, 1'b1);
        check("stall_low_cycles", low, STALL_MAX);
        rd_hold = 1'b0;
        tick();
        check_regs("after_stall");
        pulse_done();
    endtask

    task automatic abort_in_wait();
        enter_wait(1'b0);
        abort_i    = 1'b1;
        alu_done_i = 1'b1;
        access_i   = 1'b1;
        write_i    = 1'b1;
        data_sel_i = 1'b0;
        tick();
        m_active = 1'b0;
        m_words  = 0;
        m_cols   = 0;
        check_idle("abort");
        check("abort_clkreq_hold", clk_req_o, 1'b1);
        tick();
        check("abort_clkreq_drop", clk_req_o, 1'b0);
        check_idle("abort_next");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_idle("reset");
        check("reset_clkreq", clk_req_o, 1'b0);
        #6 HRESETn = 1'b1;
        tick();

        // Data write with no job: rejected, nothing loaded.
        do_write();

        // abort beats a simultaneous start.
        start_i  = 1'b1;
        abort_i  = 1'b1;
        access_i = 1'b1;
        write_i  = 1'b1;
        tick();
        check("start_abort_busy", busy_o, 1'b0);
        check("start_abort_clkreq", clk_req_o, 1'b0);

        // Full job with a result read held across columns 3..7.
        do_start();
        load_phase();
        compute_all(3);
        check_job_done("job_a");
        do_read_short();
        do_write();

        // New job from DONE; stall timeout at column 2, then abort at column 4.
        do_start();
        load_phase();
        repeat (2) begin
            enter_wait(1'b0);
            wait_gap($urandom_range(0, 3));
            pulse_done();
        end
        stall_test();
        enter_wait(1'b0);
        pulse_done();
        abort_in_wait();

        // Asynchronous reset while in CALC.
        do_start();
        load_phase();
        #2 HRESETn = 1'b0;
        #1;
        check_idle("async_rst");
        check("async_rst_clkreq", clk_req_o, 1'b0);
        m_active = 1'b0;
        m_words  = 0;
        m_cols   = 0;
        #4 HRESETn = 1'b1;
        tick();
        check_idle("post_rst");

        // Clean job after reset, then abort from DONE.
        do_start();
        load_phase();
        compute_all(-1);
        check_job_done("job_d");
        abort_i    = 1'b1;
        access_i   = 1'b1;
        write_i    = 1'b1;
        data_sel_i = 1'b0;
        @(negedge HCLK);
        check("done_abort_err", pslverr_o, 1'b0);
        tick();
        m_active = 1'b0;
        m_words  = 0;
        m_cols   = 0;
        check_idle("done_abort");
        check("done_abort_clkreq_hold", clk_req_o, 1'b1);
        tick();
        check("done_abort_clkreq_drop", clk_req_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
